bmp_extent_scan: RTL
====================

BMP_EXTENT_SCAN -- requirements
Module: bmp_extent_scan

Interface
REQ-001 SHALL have parameter ROWS, default 64, meaning number of bitmap rows (each ROWS-bit column slice).
REQ-002 SHALL have parameter COLS, default 24, meaning number of bitmap columns (each COLS-bit row slice).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alustart  input  1  one-cycle pulse: new bitmap loaded upstream, start scan.
REQ-006 SHALL have ports toprowin / botrowin  input  COLS  row slices from upstream, valid while rowtopready / rowbotready is high.
REQ-007 SHALL have port columnin  input  ROWS  column slice, valid while colready is high.
REQ-008 SHALL have ports rowtopready, rowbotready, colready  input  1 each  upstream slice-valid strobes.
REQ-009 SHALL have ports nextrowtop, nextrowbot, nextcol  output  1 each  one-cycle slice request pulses.
REQ-010 SHALL have ports top_idx, bot_idx  output  6  first non-zero row found scanning down from 63 / up from 0.
REQ-011 SHALL have ports col_hi, col_lo  output  5  highest / lowest column index containing a set pixel.
REQ-012 SHALL have port pixcount  output  11  total set pixels in the bitmap.
REQ-013 SHALL have ports done, empty  output  1 each  results valid (level) / bitmap has no set pixel.

Function
REQ-014 SHALL implement FSM IDLE -> TOPSCAN -> BOTSCAN -> COLSCAN -> DONE; DONE holds until next alustart.
REQ-015 Request handshake: on entering a scan step, pulse the request for exactly 1 cycle, then wait (any number of cycles) for the matching ready; sample data in the cycle ready is high; next request no earlier than the following cycle.
REQ-016 Ready strobes arriving without an outstanding request SHALL be ignored.
REQ-017 TOPSCAN: row counter starts 63, decrements per slice; first non-zero toprowin -> top_idx = counter, go BOTSCAN.
REQ-018 TOPSCAN all 64 rows zero -> empty=1, top_idx=0, bot_idx=0, col_hi=0, col_lo=0, pixcount=0, go DONE directly (no BOTSCAN/COLSCAN requests).
REQ-019 BOTSCAN: counter starts 0, increments; first non-zero botrowin -> bot_idx = counter, go COLSCAN.
REQ-020 COLSCAN: exactly COLS slices requested, column index 23 down to 0; first non-zero column -> col_hi; each later non-zero column overwrites col_lo (col_lo also set on first hit).
REQ-021 After column index 0 is sampled -> DONE, done=1 the next cycle.
REQ-022 Counters SHALL NOT wrap: TOPSCAN stops at row 0, COLSCAN stops at column 0.
REQ-023 alustart in any state (including mid-scan) SHALL clear done, empty and all results and restart at TOPSCAN; a ready for the aborted request SHALL be ignored.
REQ-024 alustart coincident with a ready: alustart wins.
REQ-025 Results SHALL be registered and stable throughout DONE.

Reset
REQ-026 rst SHALL force IDLE; all request pulses, done, empty, top_idx, bot_idx, col_hi, col_lo, pixcount = 0 the following cycle.
REQ-027 rst SHALL dominate alustart and all ready strobes; rst mid-scan abandons the scan.

Configuration
REQ-028 With BMP_SCAN_PIXCOUNT_EN defined: pixcount accumulates popcount(columnin) on every COLSCAN sample, saturating at 1536.
REQ-029 Without BMP_SCAN_PIXCOUNT_EN: no popcount logic; pixcount tied to 0; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold: FSM state typedef, ROWS/COLS defaults, index widths (6, 5), pixcount width (11), saturation constant 1536.
REQ-031 Popcount SHALL be a sub-module bmp_popcount64 (64-bit in, 7-bit out, combinational), instantiated only under BMP_SCAN_PIXCOUNT_EN.

Verification
REQ-032 Single pixel at row 10, column 5; ready 1 cycle after each request -> top_idx=10, bot_idx=10, col_hi=5, col_lo=5, pixcount=1, empty=0.
REQ-033 All-zero bitmap -> exactly 64 nextrowtop pulses, 0 nextrowbot, 0 nextcol, done=1, empty=1.
REQ-034 Full bitmap (all ones), ready delays random 1-5 cycles -> top_idx=63, bot_idx=0, col_hi=23, col_lo=0, pixcount=1536.
REQ-035 alustart asserted during COLSCAN at column 12 with a pending ready -> results cleared, next request is nextrowtop, stale ready ignored.
REQ-036 rst asserted mid-BOTSCAN -> all outputs 0 next cycle, no requests until alustart.
REQ-037 Build without BMP_SCAN_PIXCOUNT_EN, rerun REQ-034 -> identical indices, pixcount=0.

Source files
------------

// File: rtl/bmp_extent_scan_pkg.sv
// Shared types and constants for the bitmap extent scanner.
package bmp_extent_scan_pkg;
  localparam int ROWS_DEF  = 64;
  localparam int COLS_DEF  = 24;
  localparam int ROW_IDX_W = 6;
  localparam int COL_IDX_W = 5;
  localparam int PIX_W     = 11;
  localparam logic [PIX_W-1:0] PIX_SAT = 11'd1536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOP,
    ST_BOT,
    ST_COL,
    ST_DONE
  } state_t;
endpackage

// File: rtl/bmp_extent_scan_popcount64.sv
// Combinational population count of a 64-bit column slice.
module bmp_popcount64 (
  input  logic [63:0] din,
  output logic [6:0]  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, din[i]};
    end
  end
endmodule

// File: rtl/bmp_extent_scan.sv
// Scans an upstream bitmap slice by slice for its row/column extents and pixel count.
// Pixel counting is built only when BMP_SCAN_PIXCOUNT_EN is defined; otherwise pixcount reads 0.
module bmp_extent_scan
  import bmp_extent_scan_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alustart,
  input  logic [COLS-1:0]      toprowin,
  input  logic [COLS-1:0]      botrowin,
  input  logic [ROWS-1:0]      columnin,
  input  logic                 rowtopready,
  input  logic                 rowbotready,
  input  logic                 colready,
  output logic                 nextrowtop,
  output logic                 nextrowbot,
  output logic                 nextcol,
  output logic [ROW_IDX_W-1:0] top_idx,
  output logic [ROW_IDX_W-1:0] bot_idx,
  output logic [COL_IDX_W-1:0] col_hi,
  output logic [COL_IDX_W-1:0] col_lo,
  output logic [PIX_W-1:0]     pixcount,
  output logic                 done,
  output logic                 empty
);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(ROWS - 1);
  localparam logic [COL_IDX_W-1:0] COL_LAST = COL_IDX_W'(COLS - 1);

  state_t               state, state_nx;
  logic [ROW_IDX_W-1:0] row_cnt;
  logic [COL_IDX_W-1:0] col_cnt;
  logic                 issue, pend, found;
  logic                 rdy_sel, hit;
  logic                 top_nz, bot_nz, col_nz;

  assign top_nz = |toprowin;
  assign bot_nz = |botrowin;
  assign col_nz = |columnin;

  always_comb begin
    rdy_sel = 1'b0;
    case (state)
      ST_TOP:  rdy_sel = rowtopready;
      ST_BOT:  rdy_sel = rowbotready;
      ST_COL:  rdy_sel = colready;
      default: rdy_sel = 1'b0;
    endcase
  end

  // Only a ready answering an already-issued request counts; alustart beats it.
  assign hit = pend & rdy_sel & ~alustart;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (alustart) begin
      state_nx = ST_TOP;
    end else if (hit) begin
      case (state)
        ST_TOP: begin
          if (top_nz)              state_nx = ST_BOT;
          else if (row_cnt == '0)  state_nx = ST_DONE;
        end
        ST_BOT: if (bot_nz || row_cnt == ROW_LAST) state_nx = ST_COL;
        ST_COL: if (col_cnt == '0) state_nx = ST_DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    nextrowtop = 1'b0;
    nextrowbot = 1'b0;
    nextcol    = 1'b0;
    case (state)
      ST_TOP:  nextrowtop = issue;
      ST_BOT:  nextrowbot = issue;
      ST_COL:  nextcol    = issue;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue <= 1'b0; pend <= 1'b0; found <= 1'b0;
      done <= 1'b0; empty <= 1'b0;
      row_cnt <= '0; col_cnt <= '0;
      top_idx <= '0; bot_idx <= '0; col_hi <= '0; col_lo <= '0;
    end else if (alustart) begin
      issue <= 1'b1; pend <= 1'b0; found <= 1'b0;
      done <= 1'b0; empty <= 1'b0;
      row_cnt <= ROW_LAST; col_cnt <= COL_LAST;
      top_idx <= '0; bot_idx <= '0; col_hi <= '0; col_lo <= '0;
    end else begin
      if (issue) begin
        issue <= 1'b0;
        pend  <= 1'b1;
      end
      if (hit) begin
        pend  <= 1'b0;
        issue <= 1'b1;
        case (state)
          ST_TOP: begin
            if (top_nz) begin
              top_idx <= row_cnt;
              row_cnt <= '0;
            end else if (row_cnt == '0) begin
              issue <= 1'b0; done <= 1'b1; empty <= 1'b1;
            end else begin
              row_cnt <= row_cnt - 1'b1;
            end
          end
          ST_BOT: begin
            if (bot_nz || row_cnt == ROW_LAST) bot_idx <= row_cnt;
            else                               row_cnt <= row_cnt + 1'b1;
          end
          ST_COL: begin
            if (col_nz) begin
              if (!found) col_hi <= col_cnt;
              col_lo <= col_cnt;
              found  <= 1'b1;
            end
            if (col_cnt == '0) begin
              issue <= 1'b0; done <= 1'b1;
            end else begin
              col_cnt <= col_cnt - 1'b1;
            end
          end
          default: issue <= 1'b0;
        endcase
      end
    end
  end

`ifdef BMP_SCAN_PIXCOUNT_EN
  logic [6:0]     pop;
  logic [PIX_W:0] pix_sum;

  bmp_popcount64 u_popcount (
    .din (64'(columnin)),
    .cnt (pop)
  );

  assign pix_sum = {1'b0, pixcount} + {{(PIX_W - 6){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst || alustart)
      pixcount <= '0;
    else if (hit && state == ST_COL)
      pixcount <= (pix_sum > {1'b0, PIX_SAT}) ? PIX_SAT : pix_sum[PIX_W-1:0];
  end
`else
  assign pixcount = '0;
`endif
endmodule
